// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register stage with optional 2-entry skid buffer and bubble counter
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [DATA_W-1:0]  r_main_data;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [DATA_W-1:0]  r_skid_data;
  logic [CNT_W-1:0]   r_bubble_cnt;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_load_main_in;
  logic               w_load_main_skid;
  logic               w_load_skid;

  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next-state and slot-load decisions; flush overrides everything and drops the offered beat.
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_next_state   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            // Only reachable with a skid slot; single-entry mode gates in_ready on out_ready.
            if (SKID != 0) begin
              w_load_skid  = 1'b1;
              w_next_state = ST_FULL;
            end
          end else if (w_out_fire) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_load_main_skid = 1'b1;
            w_next_state     = ST_ONE;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // State register; reset discards all held beats without waiting for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Main and skid payload slots; main keeps its data across a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic r_in_ready;
      // Registered ready breaks the out_ready -> in_ready combinational path.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_in_ready <= 1'b0;
        end else begin
          r_in_ready <= (w_next_state != ST_FULL);
        end
      end
      assign in_ready = r_in_ready;
    end else begin : g_single
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Saturating count of cycles where downstream was ready but starved; flush does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (out_ready && !out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign out_data   = r_main_data;
  assign occupancy  = r_state;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed vector bench for pipe_stage_skid in skid and single-entry modes
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  typedef struct {
    logic              iv;
    logic              orr;
    logic              fl;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              e_ir;
    logic              e_ov;
    logic [1:0]        e_occ;
    logic [DATA_W-1:0] e_od;
    logic [CTRL_W-1:0] e_oc;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_occ;
  logic [CNT_W-1:0]  s_bubble;

  logic              n_in_ready, n_out_valid;
  logic [CTRL_W-1:0] n_out_ctrl;
  logic [DATA_W-1:0] n_out_data;
  logic [1:0]        n_occ;
  logic [CNT_W-1:0]  n_bubble;

  int checks   = 0;
  int failures = 0;

  vec_t skid_tab[24];
  vec_t single_tab[9];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) u_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occ), .bubble_cnt(s_bubble)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(CNT_W)) u_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .occupancy(n_occ), .bubble_cnt(n_bubble)
  );

  function automatic vec_t mk(input logic iv, input logic orr, input logic fl,
                              input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                              input logic e_ir, input logic e_ov, input logic [1:0] e_occ,
                              input logic [DATA_W-1:0] e_od, input logic [CTRL_W-1:0] e_oc);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.d = d; v.c = c;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_occ = e_occ; v.e_od = e_od; v.e_oc = e_oc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic orr, input logic fl,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    in_valid  = iv;
    out_ready = orr;
    flush     = fl;
    in_data   = d;
    in_ctrl   = c;
  endtask

  task automatic run_vec(input vec_t v, input bit single, input int idx);
    string p;
    @(negedge clk);
    drive(v.iv, v.orr, v.fl, v.d, v.c);
    #1;
    p = single ? $sformatf("single[%0d]", idx) : $sformatf("skid[%0d]", idx);
    if (single) begin
      chk({p, ".in_ready"},  {31'd0, n_in_ready},  {31'd0, v.e_ir});
      chk({p, ".out_valid"}, {31'd0, n_out_valid}, {31'd0, v.e_ov});
      chk({p, ".occupancy"}, {30'd0, n_occ},       {30'd0, v.e_occ});
      chk({p, ".out_data"},  n_out_data,           v.e_od);
      chk({p, ".out_ctrl"},  {24'd0, n_out_ctrl},  {24'd0, v.e_oc});
    end else begin
      chk({p, ".in_ready"},  {31'd0, s_in_ready},  {31'd0, v.e_ir});
      chk({p, ".out_valid"}, {31'd0, s_out_valid}, {31'd0, v.e_ov});
      chk({p, ".occupancy"}, {30'd0, s_occ},       {30'd0, v.e_occ});
      chk({p, ".out_data"},  s_out_data,           v.e_od);
      chk({p, ".out_ctrl"},  {24'd0, s_out_ctrl},  {24'd0, v.e_oc});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
  endtask

  localparam logic [DATA_W-1:0] DA = 32'h11, DB = 32'h22, DC = 32'h33, DD = 32'h44;
  localparam logic [CTRL_W-1:0] CA = 8'h01,  CB = 8'h02,  CC = 8'h03,  CD = 8'h04;

  initial begin
    //                     iv   or   fl   data ctrl  ir   ov   occ  od   oc
    skid_tab[0]  = mk(1'b1,1'b1,1'b0, DA, CA, 1'b1,1'b0,2'd0, 32'h0, 8'h0);
    skid_tab[1]  = mk(1'b1,1'b1,1'b0, DB, CB, 1'b1,1'b1,2'd1, DA,    CA);
    skid_tab[2]  = mk(1'b1,1'b1,1'b0, DC, CC, 1'b1,1'b1,2'd1, DB,    CB);
    skid_tab[3]  = mk(1'b0,1'b1,1'b0, '0, '0, 1'b1,1'b1,2'd1, DC,    CC);
    skid_tab[4]  = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DC,    8'h0);
    skid_tab[5]  = mk(1'b1,1'b0,1'b0, DA, CA, 1'b1,1'b0,2'd0, DC,    8'h0);
    skid_tab[6]  = mk(1'b1,1'b0,1'b0, DB, CB, 1'b1,1'b1,2'd1, DA,    CA);
    skid_tab[7]  = mk(1'b1,1'b0,1'b0, DC, CC, 1'b0,1'b1,2'd2, DA,    CA);
    skid_tab[8]  = mk(1'b1,1'b1,1'b0, DC, CC, 1'b0,1'b1,2'd2, DA,    CA);
    skid_tab[9]  = mk(1'b1,1'b1,1'b0, DC, CC, 1'b1,1'b1,2'd1, DB,    CB);
    skid_tab[10] = mk(1'b0,1'b1,1'b0, '0, '0, 1'b1,1'b1,2'd1, DC,    CC);
    skid_tab[11] = mk(1'b0,1'b1,1'b0, '0, '0, 1'b1,1'b0,2'd0, DC,    8'h0);
    skid_tab[12] = mk(1'b1,1'b0,1'b0, DA, CA, 1'b1,1'b0,2'd0, DC,    8'h0);
    skid_tab[13] = mk(1'b1,1'b0,1'b0, DB, CB, 1'b1,1'b1,2'd1, DA,    CA);
    skid_tab[14] = mk(1'b1,1'b1,1'b1, DD, CD, 1'b0,1'b1,2'd2, DA,    CA);
    skid_tab[15] = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DA,    8'h0);
    skid_tab[16] = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DA,    8'h0);
    skid_tab[17] = mk(1'b1,1'b1,1'b1, DD, CD, 1'b1,1'b0,2'd0, DA,    8'h0);
    skid_tab[18] = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DA,    8'h0);
    skid_tab[19] = mk(1'b1,1'b0,1'b0, DA, CA, 1'b1,1'b0,2'd0, DA,    8'h0);
    skid_tab[20] = mk(1'b1,1'b0,1'b0, DB, CB, 1'b1,1'b1,2'd1, DA,    CA);
    skid_tab[21] = mk(1'b0,1'b1,1'b0, '0, '0, 1'b0,1'b1,2'd2, DA,    CA);
    skid_tab[22] = mk(1'b0,1'b1,1'b0, '0, '0, 1'b1,1'b1,2'd1, DB,    CB);
    skid_tab[23] = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DB,    8'h0);

    single_tab[0] = mk(1'b1,1'b1,1'b0, DA, CA, 1'b1,1'b0,2'd0, 32'h0, 8'h0);
    single_tab[1] = mk(1'b1,1'b0,1'b0, DB, CB, 1'b0,1'b1,2'd1, DA,    CA);
    single_tab[2] = mk(1'b1,1'b1,1'b0, DB, CB, 1'b1,1'b1,2'd1, DA,    CA);
    single_tab[3] = mk(1'b1,1'b0,1'b0, DC, CC, 1'b0,1'b1,2'd1, DB,    CB);
    single_tab[4] = mk(1'b1,1'b1,1'b0, DC, CC, 1'b1,1'b1,2'd1, DB,    CB);
    single_tab[5] = mk(1'b0,1'b1,1'b0, '0, '0, 1'b1,1'b1,2'd1, DC,    CC);
    single_tab[6] = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DC,    8'h0);
    single_tab[7] = mk(1'b1,1'b1,1'b1, DD, CD, 1'b1,1'b0,2'd0, DC,    8'h0);
    single_tab[8] = mk(1'b0,1'b0,1'b0, '0, '0, 1'b1,1'b0,2'd0, DC,    8'h0);

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    chk("reset.in_ready_skid",   {31'd0, s_in_ready},  32'd0);
    chk("reset.in_ready_single", {31'd0, n_in_ready},  32'd1);
    chk("reset.out_valid",       {31'd0, s_out_valid}, 32'd0);
    chk("reset.occupancy",       {30'd0, s_occ},       32'd0);
    chk("reset.out_data",        s_out_data,           32'd0);
    chk("reset.out_ctrl",        {24'd0, s_out_ctrl},  32'd0);
    chk("reset.bubble_cnt",      {28'd0, s_bubble},    32'd0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release.in_ready_before_edge", {31'd0, s_in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("release.in_ready_after_edge",  {31'd0, s_in_ready}, 32'd1);

    for (int i = 0; i < 24; i++) run_vec(skid_tab[i], 1'b0, i);

    do_reset();
    for (int i = 0; i < 9; i++) run_vec(single_tab[i], 1'b1, i);

    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, '0, '0);
      #1;
      chk($sformatf("bubble[%0d]", k), {28'd0, s_bubble}, (k < 15) ? k : 15);
    end

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, DA, CA);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, DB, CB);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("async.occupancy_full", {30'd0, s_occ},    32'd2);
    chk("async.bubble_held",    {28'd0, s_bubble}, 32'd15);
    #2;
    reset = 1'b1;
    #1;
    chk("async.out_valid",  {31'd0, s_out_valid}, 32'd0);
    chk("async.occupancy",  {30'd0, s_occ},       32'd0);
    chk("async.bubble_cnt", {28'd0, s_bubble},    32'd0);
    chk("async.out_ctrl",   {24'd0, s_out_ctrl},  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameters: DATA_W, default 32, data payload width in bits.
REQ-002 Parameters: CTRL_W, default 8, control-bit bundle width (reg_write, mem_to_reg, alu_op, etc.).
REQ-003 Parameters: SKID, default 1; 1 = 2-entry skid mode with registered in_ready; 0 = single-entry mode with combinational in_ready.
REQ-004 Parameters: CNT_W, default 16, bubble counter width in bits.
REQ-005 Reset is named reset and is asynchronous, active-high; the clock is clk.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 flush  input  1  synchronous kill of all held and offered beats.
REQ-009 in_valid  input  1  upstream beat offered.
REQ-010 in_ready  output  1  stage can accept a beat.
REQ-011 in_ctrl  input  CTRL_W  upstream control bits.
REQ-012 in_data  input  DATA_W  upstream payload (operands, PC+4, immediate, register indices).
REQ-013 out_valid  output  1  beat presented downstream.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 out_ctrl  output  CTRL_W  control bits; all zero when out_valid=0.
REQ-016 out_data  output  DATA_W  payload of the head beat.
REQ-017 occupancy  output  2  beats held: 0, 1 or 2.
REQ-018 bubble_cnt  output  CNT_W  count of starved downstream cycles.

Function
REQ-019 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both are evaluated on the rising edge of clk.
REQ-020 States: EMPTY (occupancy 0), ONE (main slot valid), FULL (main and skid slots valid); FULL is reachable only when SKID=1.
REQ-021 EMPTY: in_fire loads the main slot -> ONE; otherwise stay.
REQ-022 ONE: in_fire & out_fire -> main slot reloads from input, stay ONE; in_fire & !out_fire -> skid slot loads, go FULL (SKID=1); !in_fire & out_fire -> EMPTY.
REQ-023 FULL: in_ready=0; out_fire -> main slot takes skid contents, go ONE; otherwise hold both.
REQ-024 SKID=1: in_ready is a flop output equal to (next state != FULL); no combinational path from out_ready to in_ready.
REQ-025 SKID=0: in_ready = !out_valid | out_ready (combinational), giving full throughput with a single entry.
REQ-026 out_valid = (state != EMPTY); out_ctrl/out_data come from the main slot; out_ctrl is forced to zero whenever out_valid=0 (bubble).
REQ-027 Latency: a beat accepted in cycle N with the stage EMPTY is presented on out_valid in cycle N+1.
REQ-028 Ordering: beats leave in strict acceptance order; no beat is duplicated or dropped except by flush.
REQ-029 Sustained in_valid=1 and out_ready=1 yields one beat per cycle in both modes.
REQ-030 flush has priority over all other events: the next state is EMPTY, both slots are invalidated, a beat offered in the same cycle is discarded even if in_fire, and an out_fire in the same cycle still completes.
REQ-031 After flush: out_valid=0 and out_ctrl=0 next cycle; out_data holds its prior value; in_ready=1 next cycle.
REQ-032 bubble_cnt increments by 1 in every cycle with out_ready=1 and out_valid=0, saturates at 2^CNT_W-1, and is unaffected by flush.
REQ-033 When upstream drops in_valid while the stage is FULL, the stage drains both beats in order before returning to EMPTY.

Reset
REQ-034 While reset=1: state EMPTY; occupancy=0; out_valid=0; out_ctrl=0; out_data=0; bubble_cnt=0; both slots cleared; in_ready=0 for SKID=1.
REQ-035 First rising edge after reset deasserts: in_ready=1 (SKID=1); in_ready follows REQ-025 immediately (SKID=0).
REQ-036 Reset asserted mid-operation, including in FULL, discards all held beats immediately, without waiting for a clock edge.

Verification
REQ-037 SKID=1, beats A=0x11, B=0x22, C=0x33 on consecutive cycles with out_ready=1 -> out_data 0x11, 0x22, 0x33 on cycles N+1..N+3, with in_ready=1 throughout.
REQ-038 SKID=1, out_ready=0, offer A then B -> occupancy 1 then 2, in_ready=0, C held off; then raise out_ready -> A then B in order, and C is accepted the cycle after in_ready rises.
REQ-039 FULL with out_ready=1, flush, and in_valid (D=0x44) in the same cycle -> A leaves, next cycle out_valid=0, out_ctrl=0, occupancy=0, and D never appears.
REQ-040 CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and holds.
REQ-041 SKID=0, out_ready toggling 1/0 with in_valid=1 -> in_ready tracks !out_valid | out_ready in the same cycle and occupancy never exceeds 1.
REQ-042 Reset pulse asserted between clock edges while FULL -> out_valid=0 and occupancy=0 before the next edge, and bubble_cnt=0.
